// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus field widths.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W  = 7;
    localparam int unsigned I2C_BYTE_W  = 8;
    localparam logic        I2C_RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_slv_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer, optional 3-sample majority filter and bus event detection.
// Define I2C_SLAVE_GLITCH_FILTER_EN to enable the filter (adds 1 clk of edge latency).
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_raw;
    logic                   sda_raw;
    logic                   scl_s;
    logic                   scl_prev;
    logic                   sda_prev;

    // Chains reset high so an idle bus does not produce a spurious edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_raw = scl_sync[SYNC_STAGES-1];
    assign sda_raw = sda_sync[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_hist <= '1;
            sda_hist <= '1;
        end else begin
            scl_hist <= {scl_hist[0], scl_raw};
            sda_hist <= {sda_hist[0], sda_raw};
        end
    end

    assign scl_s = (scl_raw & scl_hist[0]) | (scl_raw & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
    assign sda_s = (sda_raw & sda_hist[0]) | (sda_raw & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
`else
    assign scl_s = scl_raw;
    assign sda_s = sda_raw;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target endpoint: 7-bit address match, byte write/read, open-drain SDA, no stretching.
// Optional SCL/SDA glitch filter is enabled with I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scl_i,
    inout  wire                   sda_io,
    output logic [I2C_BYTE_W-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic [I2C_BYTE_W-1:0] tx_data_i,
    output logic                  tx_req_o,
    output logic                  busy_o,
    output logic                  nack_o
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .scl_i    (scl_i),
        .sda_i    (sda_io),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_s    (sda_s)
    );

    i2c_slv_state_e        state, state_next;
    logic [I2C_BYTE_W-1:0] shreg, shreg_next;
    logic [2:0]            bit_cnt, cnt_next;
    logic                  sda_oe, oe_next;
    logic                  phase, phase_next;  // second half of a two-fall ACK step
    logic                  rw, rw_next;
    logic                  rx_pend, rx_pend_next;
    logic [I2C_BYTE_W-1:0] rx_data_next;
    logic                  rx_valid_next, tx_req_next, busy_next, nack_next;

    assign sda_io = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            sda_oe     <= 1'b0;
            phase      <= 1'b0;
            rw         <= 1'b0;
            rx_pend    <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            tx_req_o   <= 1'b0;
            busy_o     <= 1'b0;
            nack_o     <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            bit_cnt    <= cnt_next;
            sda_oe     <= oe_next;
            phase      <= phase_next;
            rw         <= rw_next;
            rx_pend    <= rx_pend_next;
            rx_data_o  <= rx_data_next;
            rx_valid_o <= rx_valid_next;
            tx_req_o   <= tx_req_next;
            busy_o     <= busy_next;
            nack_o     <= nack_next;
        end
    end

    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        cnt_next      = bit_cnt;
        oe_next       = sda_oe;
        phase_next    = phase;
        rw_next       = rw;
        rx_pend_next  = 1'b0;
        rx_data_next  = rx_data_o;
        rx_valid_next = rx_pend;
        tx_req_next   = 1'b0;
        busy_next     = busy_o;
        nack_next     = 1'b0;

        if (start_det) begin
            state_next = ADDR;
            cnt_next   = '0;
            oe_next    = 1'b0;
            phase_next = 1'b0;
        end else if (stop_det) begin
            state_next = IDLE;
            oe_next    = 1'b0;
            phase_next = 1'b0;
            busy_next  = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    shreg_next = {shreg[6:0], sda_s};
                    cnt_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (shreg[6:0] == SLAVE_ADDR) begin
                            busy_next   = 1'b1;
                            rw_next     = sda_s;
                            tx_req_next = (sda_s == I2C_RW_READ);
                            phase_next  = 1'b0;
                            state_next  = ADDR_ACK;
                        end else begin
                            busy_next  = 1'b0;
                            state_next = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        oe_next    = 1'b1;
                        phase_next = 1'b1;
                    end else begin
                        phase_next = 1'b0;
                        cnt_next   = '0;
                        if (rw == I2C_RW_READ) begin
                            shreg_next = tx_data_i;
                            oe_next    = ~tx_data_i[7];
                            state_next = RD_DATA;
                        end else begin
                            oe_next    = 1'b0;
                            state_next = WR_DATA;
                        end
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shreg_next = {shreg[6:0], sda_s};
                    cnt_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data_next = {shreg[6:0], sda_s};
                        rx_pend_next = 1'b1;
                        phase_next   = 1'b0;
                        state_next   = WR_ACK;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        oe_next    = 1'b1;
                        phase_next = 1'b1;
                    end else begin
                        oe_next    = 1'b0;
                        phase_next = 1'b0;
                        state_next = WR_DATA;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt == 3'd7) begin
                        oe_next    = 1'b0;
                        cnt_next   = '0;
                        phase_next = 1'b0;
                        state_next = RD_ACK;
                    end else begin
                        shreg_next = {shreg[6:0], 1'b0};
                        oe_next    = ~shreg[6];
                        cnt_next   = bit_cnt + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (scl_rise && !phase) begin
                        if (!sda_s) begin
                            tx_req_next = 1'b1;
                            phase_next  = 1'b1;
                        end else begin
                            nack_next  = 1'b1;
                            busy_next  = 1'b0;
                            state_next = WAIT_STOP;
                        end
                    end else if (scl_fall && phase) begin
                        shreg_next = tx_data_i;
                        oe_next    = ~tx_data_i[7];
                        cnt_next   = '0;
                        phase_next = 1'b0;
                        state_next = RD_DATA;
                    end
                end
                WAIT_STOP: oe_next = 1'b0;
            endcase
        end
    end

endmodule
